alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle ALU datapath.
//  Executes one sys_defs::ALU_FUNC operation per accepted request on WIDTH-bit operands.
//  Results emerge after STAGES register stages, with valid/ready backpressure,
//  a result tag, zero/illegal flags and a synchronous flush.
//  Sits between issue logic (upstream) and writeback (downstream).
// PARAMETERS
//  WIDTH   32  operand/result width; legal 8..64
//  STAGES  2   pipeline depth = latency in cycles; legal 1..4
//  TAG_W   4   width of the opaque request tag carried alongside each op
// PORTS
//  clk         in   1          single clock, rising edge
//  rst_n       in   1          asynchronous active-low reset
//  flush       in   1          sync; drops all in-flight ops this edge
//  in_valid    in   1          request valid
//  in_ready    out  1          pipeline can accept request this cycle
//  in_func     in   4          ALU_FUNC code
//  in_a        in   WIDTH      operand A
//  in_b        in   WIDTH      operand B
//  in_tag      in   TAG_W      request tag
//  out_valid   out  1          result valid
//  out_ready   in   1          downstream accepts result
//  out_result  out  WIDTH      result
//  out_zero    out  1          out_result == 0
//  out_illegal out  1          in_func was not a defined ALU_FUNC
//  out_tag     out  TAG_W      tag of the op being presented
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits 0 -> out_valid=0.
//    out_result=0, out_zero=0, out_illegal=0, out_tag=0.
//    in_ready=1 once rst_n=1.
//  - Transfer rules:
//    - Input transfer on in_valid&in_ready.
//    - Output transfer on out_valid&out_ready.
//  - Stage i (0..STAGES-1) holds valid v[i] + payload.
//    - adv[last] = ~v[last] | out_ready.
//    - adv[i] = ~v[i] | adv[i+1].
//    - in_ready = adv[0] (combinational, no bubble).
//  - Stage regs load only when adv; stalled stages hold payload unchanged.
//    out_* stable while out_valid & ~out_ready.
//  - Compute is combinational on inputs.
//    Result, zero, illegal and tag are registered into stage 0.
//    Later stages only delay, so latency = STAGES cycles at full throughput (1 op/cycle).
//  - Arithmetic, mod 2^WIDTH:
//    - ADD a+b; SUB a-b.
//    - SLT signed a<b -> 1/0, zero-extended; SLTU unsigned a<b -> 1/0.
//    - AND, OR, XOR bitwise.
//    - SLL, SRL, SRA shift by b[$clog2(WIDTH)-1:0]; upper b bits ignored; SRA sign-fills.
//  - Codes 4'hA..4'hF: result 0, out_illegal=1, out_zero=1; op still flows and is handshaked.
//  - flush=1: all v[i] cleared at edge.
//    - Input not accepted that cycle; in_ready may still read 1 but the transfer is discarded.
//    - flush beats out_ready: a result presented that cycle counts as dropped.
//  - Simultaneous input and output transfer with pipeline full: allowed, occupancy unchanged.
//  - rst_n asserted mid-operation: all in-flight ops lost immediately, no partial outputs.
// TESTING  (WIDTH=32, STAGES=2, TAG_W=4)
//  1. ADD a=32'hFFFF_FFFF b=1 tag=3, out_ready=1
//     -> out_valid 2 cycles later, result 0, zero=1, tag=3.
//  2. SLT a=32'h8000_0000 b=1 -> result 1; SLTU same operands -> result 0.
//     SRA a=32'h8000_0000 b=32'h0000_0024 (shamt 4) -> result 32'hF800_0000.
//  3. Stream 6 back-to-back ADDs with out_ready=0
//     -> exactly 2 accepted, in_ready=0, out_* stable.
//     Raise out_ready -> remaining ops drain in order, 1/cycle, tags preserved.
//  4. in_func=4'hC a=5 b=7 -> result 0, illegal=1, zero=1; next op legal -> illegal=0.
//  5. Fill pipe with 2 ops, assert flush 1 cycle
//     -> out_valid=0 next cycle, neither op ever appears; following op has latency 2.
//  6. Deassert rst_n async with 2 ops in flight
//     -> out_valid=0 before next edge, all outputs 0.
//     Release -> in_ready=1, normal operation resumes.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational evaluate into stage 0, then STAGES-1 delay stages,
// with valid/ready backpressure, a carried tag, zero/illegal flags and a sync flush.
module alu_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_func,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int SH_W = $clog2(WIDTH);

   localparam logic [3:0] FN_ADD  = 4'h0;
   localparam logic [3:0] FN_SUB  = 4'h1;
   localparam logic [3:0] FN_SLT  = 4'h2;
   localparam logic [3:0] FN_SLTU = 4'h3;
   localparam logic [3:0] FN_AND  = 4'h4;
   localparam logic [3:0] FN_OR   = 4'h5;
   localparam logic [3:0] FN_XOR  = 4'h6;
   localparam logic [3:0] FN_SLL  = 4'h7;
   localparam logic [3:0] FN_SRL  = 4'h8;
   localparam logic [3:0] FN_SRA  = 4'h9;

   function automatic logic [WIDTH-1:0] alu_eval(input logic [3:0]       func,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
      logic signed [WIDTH-1:0] sa;
      logic signed [WIDTH-1:0] sb;
      logic [SH_W-1:0]         sh;
      logic [WIDTH-1:0]        r;
      sa = a;
      sb = b;
      sh = b[SH_W-1:0];
      case (func)
         FN_ADD:  r = a + b;
         FN_SUB:  r = a - b;
         FN_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
         FN_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
         FN_AND:  r = a & b;
         FN_OR:   r = a | b;
         FN_XOR:  r = a ^ b;
         FN_SLL:  r = a << sh;
         FN_SRL:  r = a >> sh;
         FN_SRA:  r = sa >>> sh;
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic func_illegal(input logic [3:0] func);
      return (func > FN_SRA);
   endfunction

   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] adv;
   logic [WIDTH-1:0]  res_p [STAGES];
   logic [TAG_W-1:0]  tag_p [STAGES];
   logic [STAGES-1:0] zero_p;
   logic [STAGES-1:0] ill_p;

   logic [WIDTH-1:0]  res_c;
   logic              zero_c;
   logic              ill_c;
   logic              in_fire;

   // A stage may advance when it or any stage downstream of it has a hole, or the sink drains.
   for (genvar gi = 0; gi < STAGES; gi++) begin : g_adv
      assign adv[gi] = out_ready | ~(&vld_p[STAGES-1:gi]);
   end

   assign in_ready = adv[0];
   assign in_fire  = in_valid & adv[0];

   assign res_c  = alu_eval(in_func, in_a, in_b);
   assign ill_c  = func_illegal(in_func);
   assign zero_c = (res_c == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p  <= '0;
         zero_p <= '0;
         ill_p  <= '0;
         for (int i = 0; i < STAGES; i++) begin
            res_p[i] <= '0;
            tag_p[i] <= '0;
         end
      end else if (flush) begin
         vld_p <= '0;
      end else begin
         // stage 0: capture evaluated result
         if (adv[0]) begin
            vld_p[0] <= in_fire;
            if (in_fire) begin
               res_p[0]  <= res_c;
               zero_p[0] <= zero_c;
               ill_p[0]  <= ill_c;
               tag_p[0]  <= in_tag;
            end
         end
         // stages 1..STAGES-1: pure delay
         for (int i = 1; i < STAGES; i++) begin
            if (adv[i]) begin
               vld_p[i] <= vld_p[i-1];
               if (vld_p[i-1]) begin
                  res_p[i]  <= res_p[i-1];
                  zero_p[i] <= zero_p[i-1];
                  ill_p[i]  <= ill_p[i-1];
                  tag_p[i]  <= tag_p[i-1];
               end
            end
         end
      end
   end

   assign out_valid   = vld_p[STAGES-1];
   assign out_result  = res_p[STAGES-1];
   assign out_zero    = zero_p[STAGES-1];
   assign out_illegal = ill_p[STAGES-1];
   assign out_tag     = tag_p[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32, STAGES=2, TAG_W=4) with hand-computed expectations.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_func = 4'h0;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic [3:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_zero;
   logic        out_illegal;
   logic [3:0]  out_tag;

   int total = 0;
   int bad   = 0;

   alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_illegal(out_illegal), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   // Directed vector table: func, a, b, expected result
   logic [3:0]  t_f [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'h2};
   logic [31:0] t_a [11] = '{32'h7, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'hF0F0_1234,
                             32'hF000_0000, 32'hFFFF_0000, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1};
   logic [31:0] t_b [11] = '{32'h5, 32'h7, 32'h1, 32'h1, 32'h0FF0_FFFF,
                             32'h0000_000F, 32'hFF00_FF00, 32'h21, 32'h24, 32'h24, 32'h8000_0000};
   logic [31:0] t_e [11] = '{32'hC, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h00F0_1234,
                             32'hF000_000F, 32'h00FF_FF00, 32'h2, 32'h0800_0000, 32'hF800_0000, 32'h0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] t);
      in_valid = 1'b1;
      in_func  = f;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
      total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", out_result); end
      total++; if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", out_zero); end
      total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
      total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%h want=0", out_tag); end
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      drive(4'h0, 32'hFFFF_FFFF, 32'h1, 4'h3);
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_lat1_valid got=%b want=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_lat2_valid got=%b want=1", out_valid); end
      total++; if (out_result !== 32'h0) begin bad++; $display("FAIL add_result got=%h want=0", out_result); end
      total++; if (out_zero !== 1'b1) begin bad++; $display("FAIL add_zero got=%b want=1", out_zero); end
      total++; if (out_tag !== 4'h3) begin bad++; $display("FAIL add_tag got=%h want=3", out_tag); end
      total++; if (out_illegal !== 1'b0) begin bad++; $display("FAIL add_illegal got=%b want=0", out_illegal); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_ops();
      out_ready = 1'b1;
      for (int k = 0; k <= 11; k++) begin
         if (k < 11) drive(t_f[k], t_a[k], t_b[k], 4'(k));
         else in_valid = 1'b0;
         tick();
         if (k >= 1) begin
            total++;
            if (out_valid !== 1'b1 || out_result !== t_e[k-1] || out_tag !== 4'(k-1)) begin
               bad++;
               $display("FAIL op_%0d got v=%b r=%h t=%h want v=1 r=%h t=%h",
                        k-1, out_valid, out_result, out_tag, t_e[k-1], 4'(k-1));
            end
         end
      end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ops_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      int idx;
      int accepted;
      logic stable;
      logic fire;
      out_ready = 1'b0;
      idx = 1;
      accepted = 0;
      stable = 1'b1;
      drive(4'h0, 32'(idx), 32'h100, 4'(idx));
      for (int c = 0; c < 6; c++) begin
         fire = in_ready;
         if (fire) accepted++;
         tick();
         if (fire) begin
            idx++;
            drive(4'h0, 32'(idx), 32'h100, 4'(idx));
         end
         if (c >= 2 && (out_valid !== 1'b1 || out_tag !== 4'h1 || out_result !== 32'h101)) stable = 1'b0;
      end
      total++; if (accepted != 2) begin bad++; $display("FAIL stall_accepted got=%0d want=2", accepted); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
      total++; if (stable !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b want=1", stable); end
      out_ready = 1'b1;
      #1;
      for (int n = 1; n <= 6; n++) begin
         total++;
         if (out_valid !== 1'b1 || out_tag !== 4'(n) || out_result !== 32'(32'h100 + n)) begin
            bad++;
            $display("FAIL drain_%0d got v=%b t=%h r=%h want v=1 t=%h r=%h",
                     n, out_valid, out_tag, out_result, 4'(n), 32'(32'h100 + n));
         end
         if (in_valid) begin
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready_%0d got=%b want=1", n, in_ready); end
         end
         tick();
         if (in_valid) begin
            idx++;
            if (idx <= 6) drive(4'h0, 32'(idx), 32'h100, 4'(idx));
            else in_valid = 1'b0;
         end
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", out_valid); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive(4'hC, 32'h5, 32'h7, 4'h9);
      tick();
      drive(4'h0, 32'h1, 32'h1, 4'hA);
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0 || out_illegal !== 1'b1 || out_zero !== 1'b1 || out_tag !== 4'h9) begin
         bad++;
         $display("FAIL illegal_op got v=%b r=%h ill=%b z=%b t=%h want v=1 r=0 ill=1 z=1 t=9",
                  out_valid, out_result, out_illegal, out_zero, out_tag);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h2 || out_illegal !== 1'b0 || out_zero !== 1'b0 || out_tag !== 4'hA) begin
         bad++;
         $display("FAIL legal_after got v=%b r=%h ill=%b z=%b t=%h want v=1 r=2 ill=0 z=0 t=a",
                  out_valid, out_result, out_illegal, out_zero, out_tag);
      end
      tick();
   endtask

   task automatic test_flush();
      logic seen;
      out_ready = 1'b0;
      drive(4'h0, 32'h10, 32'h1, 4'hB);
      tick();
      drive(4'h0, 32'h20, 32'h1, 4'hC);
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_full got=%b want=1", out_valid); end
      drive(4'h0, 32'h30, 32'h1, 4'hD);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_cleared got=%b want=0", out_valid); end
      seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b want=0", seen); end
      drive(4'h0, 32'h2, 32'h3, 4'hE);
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_next_early got=%b want=0", out_valid); end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h5 || out_tag !== 4'hE) begin
         bad++;
         $display("FAIL flush_next got v=%b r=%h t=%h want v=1 r=5 t=e", out_valid, out_result, out_tag);
      end
      tick();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(4'hF, 32'h1, 32'h2, 4'h5);
      tick();
      drive(4'h1, 32'h9, 32'h2, 4'h6);
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_tag !== 4'h5) begin
         bad++;
         $display("FAIL arst_pre got v=%b ill=%b t=%h want v=1 ill=1 t=5", out_valid, out_illegal, out_tag);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_result !== 32'h0 || out_zero !== 1'b0 || out_illegal !== 1'b0 || out_tag !== 4'h0) begin
         bad++;
         $display("FAIL arst_clear got v=%b r=%h z=%b ill=%b t=%h want all 0",
                  out_valid, out_result, out_zero, out_illegal, out_tag);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", in_ready); end
      out_ready = 1'b1;
      drive(4'h4, 32'hFF, 32'h0F, 4'h7);
      tick();
      in_valid = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_result !== 32'h0F || out_tag !== 4'h7) begin
         bad++;
         $display("FAIL arst_resume got v=%b r=%h t=%h want v=1 r=f t=7", out_valid, out_result, out_tag);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_add();
      test_ops();
      test_back_to_back();
      test_illegal();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
